video_timing_decoder: RTL



---
 rtl/video_timing_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/video_timing_decoder.sv
// Purpose: recovers pixel coordinates, data-enable, raster geometry and a lock flag from hs/vs/hb/vb.
// Latency: every output updates on the clk_sys edge of the ce_pix cycle that samples the causing edge.
// Backpressure: none; the sync stream is sampled only when ce_pix=1 and cannot be stalled.
module video_timing_decoder #(
    parameter int HTIMEOUT    = 1023,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       hs,
    input  logic       vs,
    input  logic       hb,
    input  logic       vb,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       de,
    output logic       new_line,
    output logic       new_frame,
    output logic [9:0] line_len,
    output logic [8:0] frame_lines,
    output logic [8:0] active_w,
    output logic [8:0] active_h,
    output logic       locked
);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    localparam logic [9:0] HTO = 10'(HTIMEOUT);

    logic        hs_d, vs_d, hb_d, vb_d;
    logic        hs_fall, vs_fall, hb_fall, hb_rise, vb_fall, vb_rise;
    logic [9:0]  hcnt, hcnt_nx, line_len_nx;
    logic [8:0]  vcnt, vcnt_inc, vcnt_nx, frame_lines_nx;
    logic        htimeout;
    logic [9:0]  prev_len;
    logic [8:0]  prev_lines;
    logic [7:0]  mcnt, mcnt_nx;
    logic        match;
    lock_state_t state, state_nx;

    // Edges exist only on enabled cycles; between enables the inputs may toggle freely.
    assign hs_fall = ce_pix & hs_d & ~hs;
    assign vs_fall = ce_pix & vs_d & ~vs;
    assign hb_fall = ce_pix & hb_d & ~hb;
    assign hb_rise = ce_pix & ~hb_d & hb;
    assign vb_fall = ce_pix & vb_d & ~vb;
    assign vb_rise = ce_pix & ~vb_d & vb;

    assign locked = (state == LOCKED);

    // Previous-sample registers for edge detection, idle (inactive) after reset.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_d <= 1'b1;
            vs_d <= 1'b1;
            hb_d <= 1'b1;
            vb_d <= 1'b1;
        end else if (ce_pix) begin
            hs_d <= hs;
            vs_d <= vs;
            hb_d <= hb;
            vb_d <= vb;
        end
    end

    // Next values of the line/frame counters; the lock compare needs them before they are registered.
    always_comb begin
        hcnt_nx     = hcnt;
        line_len_nx = line_len;
        if (hs_fall) begin
            // hcnt+1 would wrap at 1024 after a saturated timeout, so clamp it.
            line_len_nx = (hcnt == 10'h3FF) ? 10'h3FF : hcnt + 10'd1;
            hcnt_nx     = '0;
        end else if (ce_pix && (hcnt < HTO)) begin
            hcnt_nx = hcnt + 10'd1;
        end
        // A coincident hs fall is counted into the frame before it is captured.
        vcnt_inc       = (hs_fall && (vcnt != 9'h1FF)) ? vcnt + 9'd1 : vcnt;
        vcnt_nx        = vs_fall ? '0 : vcnt_inc;
        frame_lines_nx = vs_fall ? vcnt_inc : frame_lines;
        htimeout       = ce_pix && !hs_fall && (hcnt_nx == HTO);
    end

    // Line/frame counters, measurements and the one-clk_sys edge pulses.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            new_line    <= 1'b0;
            new_frame   <= 1'b0;
        end else begin
            hcnt        <= hcnt_nx;
            vcnt        <= vcnt_nx;
            line_len    <= line_len_nx;
            frame_lines <= frame_lines_nx;
            new_line    <= hs_fall;
            new_frame   <= vs_fall;
        end
    end

    // Active-area position and size; x is the column of the latest active pixel, so width is x+1.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            active_w <= '0;
            active_h <= '0;
            de       <= 1'b0;
        end else if (ce_pix) begin
            if (hb_fall)
                x <= '0;
            else if (!hb && !vb)
                x <= x + 9'd1;
            if (hb_rise && !vb)
                active_w <= x + 9'd1;
            if (vb_fall)
                y <= '0;
            else if (hb_rise && !vb)
                y <= y + 9'd1;
            if (vb_rise)
                active_h <= y;
            de <= ~hb & ~vb;
        end
    end

    // Lock next-state: a run of N identical frames yields N-1 matches, so lock on LOCK_FRAMES-1 matches.
    always_comb begin
        state_nx = state;
        mcnt_nx  = mcnt;
        match    = (line_len_nx == prev_len) && (frame_lines_nx == prev_lines);
        if (htimeout) begin
            state_nx = UNLOCKED;
            mcnt_nx  = '0;
        end else if (vs_fall) begin
            if (match) begin
                if (mcnt != 8'hFF)
                    mcnt_nx = mcnt + 8'd1;
                if (int'(mcnt_nx) + 1 >= LOCK_FRAMES)
                    state_nx = LOCKED;
            end else begin
                mcnt_nx  = '0;
                state_nx = UNLOCKED;
            end
        end
    end

    // Lock state register and the previous frame's geometry for comparison.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= UNLOCKED;
            mcnt       <= '0;
            prev_len   <= '0;
            prev_lines <= '0;
        end else begin
            state <= state_nx;
            mcnt  <= mcnt_nx;
            if (vs_fall) begin
                prev_len   <= line_len_nx;
                prev_lines <= frame_lines_nx;
            end
        end
    end

endmodule
